pa_rtu_dtu_halt_ctrl: RTL and testbench

- Retire-side consumer of trigger halt information; the RTU end of the DTU halt protocol.
- Takes per-instruction halt info tagged by IFU/LSU at retire, plus the DTU pending-halt request (icount).
- Converts them into debug-mode entry or breakpoint exceptions, flushes the pipe, and returns retire halt info, halt ack and pending ack to the DTU.
- Sits in RTU between the retire stage, the DTU trigger block and HAD.

---
 rtl/pa_dtu_halt_pkg.sv | 31 +++
 rtl/pa_rtu_dtu_retire_pipe.sv | 32 +++
 rtl/pa_rtu_dtu_halt_ctrl.sv | 138 +++++++++++++
 tb/tb_pa_rtu_dtu_halt_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pa_dtu_halt_pkg.sv
// Shared definitions for the RTU side of the DTU halt protocol:
// halt-info field positions, halt FSM encodings and debug cause codes.
package pa_dtu_halt_pkg;

    // Halt info layout carried with each retiring instruction
    localparam int HINFO_W      = 15;
    localparam int CAUSE_W      = 4;
    localparam int HI_HIT       = 14;
    localparam int HI_TIMING    = 13;
    localparam int HI_ACTION    = 12;
    localparam int HI_CAUSE_MSB = 11;
    localparam int HI_CAUSE_LSB = 8;
    localparam int HI_MASK_MSB  = 7;
    localparam int HI_MASK_LSB  = 0;

    // Debug cause codes, shared with the DTU
    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 4'h0;
    localparam logic [CAUSE_W-1:0] CAUSE_TRIGGER = 4'h2;
    localparam logic [CAUSE_W-1:0] CAUSE_ICOUNT  = 4'h4;

    // Halt controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BEFORE   = 3'd1,
        ST_AFTER    = 3'd2,
        ST_PEND     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DBG      = 3'd5
    } halt_st_e;

endpackage

// File: rtl/pa_rtu_dtu_retire_pipe.sv
// Registered forwarding of retire information back to the DTU.
// Halt info is zeroed on cycles without a retiring instruction so the DTU
// never sees stale trigger hits.
module pa_rtu_dtu_retire_pipe
    import pa_dtu_halt_pkg::*;
#(
    parameter int HW = HINFO_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          retire_vld,
    input  logic [HW-1:0] halt_info,
    input  logic          retire_mret,
    output logic          fwd_vld,
    output logic [HW-1:0] fwd_halt_info,
    output logic          fwd_mret
);

    // One-cycle copy of the retire event, qualified by retire_vld
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_vld       <= 1'b0;
            fwd_halt_info <= '0;
            fwd_mret      <= 1'b0;
        end else begin
            fwd_vld       <= retire_vld;
            fwd_halt_info <= retire_vld ? halt_info : '0;
            fwd_mret      <= retire_vld & retire_mret;
        end
    end

endmodule

// File: rtl/pa_rtu_dtu_halt_ctrl.sv
// RTU end of the DTU halt protocol. Turns trigger halt info tagged on the
// retiring instruction (and, optionally, the DTU pending halt) into
// debug-mode entry or breakpoint exceptions, and acks the DTU.
// Optional feature macro: E906_RTU_PENDING_HALT_EN enables the pending-halt
// (icount) path and the PEND state; without it the pending inputs are ignored.
module pa_rtu_dtu_halt_ctrl
    import pa_dtu_halt_pkg::*;
#(
    parameter int HINFO_W = 15,
    parameter int CAUSE_W = 4
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic               iu_rtu_retire_vld,
    input  logic [HINFO_W-1:0] iu_rtu_halt_info,
    input  logic               iu_rtu_retire_mret,
    input  logic               dtu_rtu_pending_halt,
    input  logic [CAUSE_W-1:0] dtu_rtu_cause,
    input  logic               had_rtu_dbg_ack,
    input  logic               rtu_yy_xx_dbgon,
    output logic               rtu_dtu_retire_vld,
    output logic [HINFO_W-1:0] rtu_dtu_retire_halt_info,
    output logic               rtu_dtu_retire_mret,
    output logic               rtu_dtu_halt_ack,
    output logic               rtu_dtu_pending_ack,
    output logic               rtu_had_dbg_req,
    output logic [CAUSE_W-1:0] rtu_had_dbg_cause,
    output logic               rtu_cp0_bkpt_expt,
    output logic               rtu_ifu_flush
);

    halt_st_e           state, state_nxt;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               action_q, action_d;
    logic               hit;

    pa_rtu_dtu_retire_pipe #(.HW(HINFO_W)) u_retire_pipe (
        .clk           (forever_cpuclk),
        .rst_n         (cpurst_b),
        .retire_vld    (iu_rtu_retire_vld),
        .halt_info     (iu_rtu_halt_info),
        .retire_mret   (iu_rtu_retire_mret),
        .fwd_vld       (rtu_dtu_retire_vld),
        .fwd_halt_info (rtu_dtu_retire_halt_info),
        .fwd_mret      (rtu_dtu_retire_mret)
    );

    assign hit = iu_rtu_retire_vld & iu_rtu_halt_info[HI_HIT];

`ifdef E906_RTU_PENDING_HALT_EN
    logic unused_sig;
    assign unused_sig = ^iu_rtu_halt_info[HI_MASK_MSB:HI_MASK_LSB];
`else
    logic unused_sig;
    assign unused_sig = ^{iu_rtu_halt_info[HI_MASK_MSB:HI_MASK_LSB],
                          dtu_rtu_pending_halt, dtu_rtu_cause};
`endif

    // State, latched cause and latched action (exception vs debug entry)
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state    <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            action_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cause_q  <= cause_d;
            action_q <= action_d;
        end
    end

    // Next state and Moore outputs; trigger hits win over the pending halt,
    // which stays asserted by the DTU and is taken on a later retire
    always_comb begin
        state_nxt           = state;
        cause_d             = cause_q;
        action_d            = action_q;
        rtu_dtu_halt_ack    = 1'b0;
        rtu_dtu_pending_ack = 1'b0;
        rtu_had_dbg_req     = 1'b0;
        rtu_had_dbg_cause   = CAUSE_NONE;
        rtu_cp0_bkpt_expt   = 1'b0;
        rtu_ifu_flush       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rtu_yy_xx_dbgon) begin
                    if (hit) begin
                        cause_d   = iu_rtu_halt_info[HI_CAUSE_MSB:HI_CAUSE_LSB];
                        action_d  = iu_rtu_halt_info[HI_ACTION];
                        state_nxt = iu_rtu_halt_info[HI_TIMING] ? ST_AFTER : ST_BEFORE;
                    end
`ifdef E906_RTU_PENDING_HALT_EN
                    else if (dtu_rtu_pending_halt && iu_rtu_retire_vld) begin
                        cause_d   = dtu_rtu_cause;
                        action_d  = 1'b0;
                        state_nxt = ST_PEND;
                    end
`endif
                end
            end
            // Instruction completes; take the halt one cycle later
            ST_AFTER: state_nxt = ST_BEFORE;
            ST_BEFORE: begin
                rtu_ifu_flush    = 1'b1;
                rtu_dtu_halt_ack = 1'b1;
                if (action_q) begin
                    rtu_cp0_bkpt_expt = 1'b1;
                    cause_d           = CAUSE_NONE;
                    action_d          = 1'b0;
                    state_nxt         = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT_ACK;
                end
            end
`ifdef E906_RTU_PENDING_HALT_EN
            ST_PEND: begin
                rtu_dtu_pending_ack = 1'b1;
                rtu_ifu_flush       = 1'b1;
                state_nxt           = ST_WAIT_ACK;
            end
`endif
            ST_WAIT_ACK: begin
                rtu_had_dbg_req   = 1'b1;
                rtu_had_dbg_cause = cause_q;
                if (had_rtu_dbg_ack) state_nxt = ST_DBG;
            end
            ST_DBG: begin
                if (!rtu_yy_xx_dbgon) begin
                    cause_d   = CAUSE_NONE;
                    action_d  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pa_rtu_dtu_halt_ctrl.sv
// Directed bench for pa_rtu_dtu_halt_ctrl. Each step drives one cycle of
// inputs and queues the outputs expected after the following clock edge.
module tb_pa_rtu_dtu_halt_ctrl;

    typedef struct packed {
        logic        rv;
        logic [14:0] hi;
        logic        mr;
        logic        hack;
        logic        pack;
        logic        dreq;
        logic [3:0]  dc;
        logic        bk;
        logic        fl;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld, mret, pend, ack, dbgon;
    logic [14:0] hinfo;
    logic [3:0]  dcause;
    logic        o_rv, o_mr, o_hack, o_pack, o_dreq, o_bk, o_fl;
    logic [14:0] o_hi;
    logic [3:0]  o_dc;

    outs_t exp_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    pa_rtu_dtu_halt_ctrl dut (
        .forever_cpuclk           (clk),
        .cpurst_b                 (rst_n),
        .iu_rtu_retire_vld        (vld),
        .iu_rtu_halt_info         (hinfo),
        .iu_rtu_retire_mret       (mret),
        .dtu_rtu_pending_halt     (pend),
        .dtu_rtu_cause            (dcause),
        .had_rtu_dbg_ack          (ack),
        .rtu_yy_xx_dbgon          (dbgon),
        .rtu_dtu_retire_vld       (o_rv),
        .rtu_dtu_retire_halt_info (o_hi),
        .rtu_dtu_retire_mret      (o_mr),
        .rtu_dtu_halt_ack         (o_hack),
        .rtu_dtu_pending_ack      (o_pack),
        .rtu_had_dbg_req          (o_dreq),
        .rtu_had_dbg_cause        (o_dc),
        .rtu_cp0_bkpt_expt        (o_bk),
        .rtu_ifu_flush            (o_fl)
    );

    function automatic outs_t mk(logic rv, logic [14:0] hi, logic mr, logic hack,
                                 logic pack, logic dreq, logic [3:0] dc,
                                 logic bk, logic fl);
        outs_t o;
        o = '{rv:rv, hi:hi, mr:mr, hack:hack, pack:pack, dreq:dreq, dc:dc, bk:bk, fl:fl};
        return o;
    endfunction

    // Drive one cycle, queue its expectation, then compare after the edge
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [14:0] h, input logic m, input logic p,
                        input logic [3:0] c, input logic a, input logic d,
                        input outs_t e);
        outs_t got, want;
        rst_n = r; vld = v; hinfo = h; mret = m; pend = p; dcause = c;
        ack = a; dbgon = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = '{rv:o_rv, hi:o_hi, mr:o_mr, hack:o_hack, pack:o_pack,
                 dreq:o_dreq, dc:o_dc, bk:o_bk, fl:o_fl};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    outs_t z;

    initial begin
        z = mk(0, 15'h0, 0, 0, 0, 0, 4'h0, 0, 0);
        rst_n = 0; vld = 0; hinfo = 0; mret = 0; pend = 0; dcause = 0;
        ack = 0; dbgon = 0;
        @(posedge clk); #1;
        step("reset",        0, 1, 15'h4203, 0, 1, 4'h4, 1, 0, z);

        // before-timing debug hit
        step("bef_hit",      1, 1, 15'h4203, 0, 0, 4'h0, 0, 0, mk(1, 15'h4203, 0, 1, 0, 0, 4'h0, 0, 1));
        step("bef_req0",     1, 0, 15'h0,    0, 0, 4'h0, 0, 0, mk(0, 15'h0, 0, 0, 0, 1, 4'h2, 0, 0));
        step("bef_req1",     1, 0, 15'h0,    0, 0, 4'h0, 0, 0, mk(0, 15'h0, 0, 0, 0, 1, 4'h2, 0, 0));
        step("bef_ack",      1, 0, 15'h0,    0, 0, 4'h0, 1, 1, z);
        step("dbg_hit_drop", 1, 1, 15'h4203, 0, 0, 4'h0, 0, 1, mk(1, 15'h4203, 0, 0, 0, 0, 4'h0, 0, 0));
        step("dbg_exit",     1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);
        step("zero_no_vld",  1, 0, 15'h4203, 0, 0, 4'h0, 0, 0, z);
        step("idle_after",   1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);

        // before-timing exception hit
        step("exc_hit",      1, 1, 15'h5201, 0, 0, 4'h0, 0, 0, mk(1, 15'h5201, 0, 1, 0, 0, 4'h0, 1, 1));
        step("exc_idle0",    1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);
        step("exc_idle1",    1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);

        // after-timing hit on an mret
        step("aft_echo",     1, 1, 15'h6201, 1, 0, 4'h0, 0, 0, mk(1, 15'h6201, 1, 0, 0, 0, 4'h0, 0, 0));
        step("aft_ack",      1, 0, 15'h0,    0, 0, 4'h0, 0, 0, mk(0, 15'h0, 0, 1, 0, 0, 4'h0, 0, 1));
        step("aft_req",      1, 0, 15'h0,    0, 0, 4'h0, 0, 0, mk(0, 15'h0, 0, 0, 0, 1, 4'h2, 0, 0));
        step("busy_hit",     1, 1, 15'h4203, 0, 0, 4'h0, 0, 0, mk(1, 15'h4203, 0, 0, 0, 1, 4'h2, 0, 0));
        step("aft_dbg",      1, 0, 15'h0,    0, 0, 4'h0, 1, 1, z);
        step("aft_exit",     1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);

        // pending halt competing with a trigger hit
        step("pend_trig",    1, 1, 15'h4201, 0, 1, 4'h4, 0, 0, mk(1, 15'h4201, 0, 1, 0, 0, 4'h0, 0, 1));
        step("pend_treq",    1, 0, 15'h0,    0, 1, 4'h4, 0, 0, mk(0, 15'h0, 0, 0, 0, 1, 4'h2, 0, 0));
        step("pend_tdbg",    1, 0, 15'h0,    0, 1, 4'h4, 1, 1, z);
        step("pend_texit",   1, 0, 15'h0,    0, 1, 4'h4, 0, 0, z);
`ifdef E906_RTU_PENDING_HALT_EN
        step("pend_ack",     1, 1, 15'h0,    0, 1, 4'h4, 0, 0, mk(1, 15'h0, 0, 0, 1, 0, 4'h0, 0, 1));
        step("pend_req",     1, 0, 15'h0,    0, 0, 4'h0, 0, 0, mk(0, 15'h0, 0, 0, 0, 1, 4'h4, 0, 0));
        step("pend_dbg",     1, 0, 15'h0,    0, 0, 4'h0, 1, 1, z);
        step("pend_exit",    1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);
`else
        step("pend_ignored", 1, 1, 15'h0,    0, 1, 4'h4, 0, 0, mk(1, 15'h0, 0, 0, 0, 0, 4'h0, 0, 0));
        step("pend_quiet",   1, 0, 15'h0,    0, 1, 4'h4, 0, 0, z);
`endif

        // reset while waiting for the HAD ack
        step("rst_hit",      1, 1, 15'h4203, 0, 0, 4'h0, 0, 0, mk(1, 15'h4203, 0, 1, 0, 0, 4'h0, 0, 1));
        step("rst_req",      1, 0, 15'h0,    0, 0, 4'h0, 0, 0, mk(0, 15'h0, 0, 0, 0, 1, 4'h2, 0, 0));
        step("rst_wait",     0, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);
        step("rst_idle",     1, 0, 15'h0,    0, 0, 4'h0, 0, 0, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
